// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and framing constants for the instruction memory loader.
package imem_loader_pkg;
   typedef enum logic [2:0] {IDLE, LEN, DATA, CKSUM, DONE, ERR} state_t;
   localparam int LEN_BYTES      = 4;
   localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles little-endian 32-bit words from accepted bytes.
// word_o is the word as it would complete with the current byte; word_valid_o marks the 4th byte.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic [7:0]  byte_i,
   output logic        word_valid_o,
   output logic [31:0] word_o
);
   localparam int CW = $clog2(BYTES_PER_WORD);
   logic [CW-1:0] r_cnt;
   logic [23:0]   r_sr;
   assign word_o       = {byte_i, r_sr};
   assign word_valid_o = en_i && (r_cnt == CW'(BYTES_PER_WORD - 1));
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_cnt <= '0;
         r_sr  <= '0;
      end else if (en_i) begin
         r_cnt <= r_cnt + CW'(1);
         r_sr  <= word_o[31:8];
      end
   end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream to instruction-memory writer; holds the core in reset until loaded.
// Optional trailing checksum word enabled by defining IMEM_LOADER_CKSUM_EN.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DW             = 32,
   parameter int MEM_SIZE_IN_KB = 1,
   parameter int NO_OF_REGS     = MEM_SIZE_IN_KB * 1024 / 4,
   parameter int ADDRW          = $clog2(NO_OF_REGS)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             byte_valid_i,
   input  logic [7:0]       byte_data_i,
   output logic             byte_ready_o,
   output logic             imem_we_o,
   output logic [ADDRW-1:0] imem_waddr_o,
   output logic [DW-1:0]    imem_wdata_o,
   output logic             core_rst_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o
);
`ifdef IMEM_LOADER_CKSUM_EN
   localparam state_t AFTER_DATA = CKSUM;
`else
   localparam state_t AFTER_DATA = DONE;
`endif
   state_t           r_state, w_next;
   logic             w_acc, w_start, w_wv, w_wr, w_last;
   logic [31:0]      w_word;
   logic [ADDRW-1:0] r_wcnt;
   logic [ADDRW:0]   r_n;
   logic             r_we, r_core_rst;
   logic [ADDRW-1:0] r_waddr;
   logic [DW-1:0]    r_wdata;
`ifdef IMEM_LOADER_CKSUM_EN
   logic [31:0]      r_sum;
`endif
   assign byte_ready_o = r_state inside {LEN, DATA, CKSUM};
   assign busy_o       = byte_ready_o;
   assign done_o       = r_state == DONE;
   assign err_o        = r_state == ERR;
   assign imem_we_o    = r_we;
   assign imem_waddr_o = r_waddr;
   assign imem_wdata_o = r_wdata;
   assign core_rst_o   = r_core_rst;
   assign w_acc        = byte_valid_i && byte_ready_o;
   assign w_start      = start_i && (r_state inside {IDLE, DONE, ERR});
   assign w_wr         = (r_state == DATA) && w_wv;
   assign w_last       = {1'b0, r_wcnt} == r_n - (ADDRW + 1)'(1);
   byte_packer u_packer (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .clr_i        (w_start),
      .en_i         (w_acc),
      .byte_i       (byte_data_i),
      .word_valid_o (w_wv),
      .word_o       (w_word)
   );
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:  w_next = start_i ? LEN : IDLE;
         LEN:   if (w_wv) w_next = (w_word == 32'd0) ? AFTER_DATA :
                                   (w_word > 32'(NO_OF_REGS)) ? ERR : DATA;
         DATA:  if (w_wv && w_last) w_next = AFTER_DATA;
`ifdef IMEM_LOADER_CKSUM_EN
         CKSUM: if (w_wv) w_next = (w_word == r_sum) ? DONE : ERR;
`endif
         DONE:  w_next = start_i ? LEN : DONE;
         ERR:   w_next = start_i ? LEN : ERR;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_wcnt     <= '0;
         r_n        <= '0;
         r_we       <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= '0;
         r_core_rst <= 1'b1;
      end else begin
         r_state    <= w_next;
         r_we       <= w_wr;
         // release the core only once DONE has held for a cycle, so the last write has landed
         r_core_rst <= !(r_state == DONE && w_next == DONE);
         if (w_start)
            r_wcnt <= '0;
         else if (w_wr && !w_last)
            r_wcnt <= r_wcnt + ADDRW'(1);
         if (r_state == LEN && w_wv)
            r_n <= w_word[ADDRW:0];
         if (w_wr) begin
            r_waddr <= r_wcnt;
            r_wdata <= w_word;
         end
      end
   end
`ifdef IMEM_LOADER_CKSUM_EN
   always_ff @(posedge clk_i) begin
      if (rst_i || w_start)
         r_sum <= '0;
      else if (w_wr)
         r_sum <= r_sum + w_word;
   end
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized byte-stream loads checked against a word-list reference model.
module tb_imem_loader;
   localparam int NREGS = 256;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, bv = 1'b0;
   logic [7:0]  bd = 8'h00;
   logic        byte_ready_o, imem_we_o, core_rst_o, busy_o, done_o, err_o;
   logic [7:0]  imem_waddr_o;
   logic [31:0] imem_wdata_o;
   int          n_chk = 0, n_err = 0;
   logic [31:0] wa_q[$], wd_q[$];
   logic [31:0] prog[NREGS];

   imem_loader dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .byte_valid_i(bv), .byte_data_i(bd),
      .byte_ready_o(byte_ready_o), .imem_we_o(imem_we_o), .imem_waddr_o(imem_waddr_o),
      .imem_wdata_o(imem_wdata_o), .core_rst_o(core_rst_o), .busy_o(busy_o),
      .done_o(done_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (imem_we_o) begin
         wa_q.push_back(32'(imem_waddr_o));
         wd_q.push_back(imem_wdata_o);
      end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int bub, input bit pulse_start);
      bit acc = 1'b0;
      while ($urandom_range(0, 99) < bub) begin
         @(negedge clk); bv = 1'b0; start = 1'b0;
         @(posedge clk);
      end
      for (int i = 0; i < 8 && !acc; i++) begin
         @(negedge clk); bv = 1'b1; bd = b; start = pulse_start;
         acc = byte_ready_o;
         @(posedge clk);
      end
      if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_start();
      @(negedge clk); bv = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("start_core_rst", core_rst_o, 1);
      chk("start_done_clr", done_o, 0);
      chk("start_err_clr", err_o, 0);
      chk("start_busy", busy_o, 1);
   endtask

   task automatic run_load(input logic [31:0] n, input int bub, input bit bad_ck, input int start_at);
      logic [7:0]  bytes[$];
      logic [31:0] sum = 0, ck, w;
      int          nd;
      bit          ok;
      nd = (n <= NREGS) ? int'(n) : 0;
      bytes = {n[7:0], n[15:8], n[23:16], n[31:24]};
      for (int i = 0; i < nd; i++) begin
         w = prog[i];
         bytes.push_back(w[7:0]); bytes.push_back(w[15:8]);
         bytes.push_back(w[23:16]); bytes.push_back(w[31:24]);
         sum += w;
      end
`ifdef IMEM_LOADER_CKSUM_EN
      ck = bad_ck ? sum + 32'd1 : sum;
      if (n <= NREGS) begin
         bytes.push_back(ck[7:0]); bytes.push_back(ck[15:8]);
         bytes.push_back(ck[23:16]); bytes.push_back(ck[31:24]);
      end
      ok = (n <= NREGS) && !bad_ck;
`else
      ck = sum;
      ok = (n <= NREGS) && (bad_ck || !bad_ck);
`endif
      wa_q.delete(); wd_q.delete();
      do_start();
      foreach (bytes[i]) send_byte(bytes[i], bub, i == start_at);
      @(negedge clk); bv = 1'b0; start = 1'b0;
      chk("end_done", done_o, 32'(ok));
      chk("end_err", err_o, 32'(!ok));
      chk("end_core_rst_held", core_rst_o, 1);
      chk("end_ready", byte_ready_o, 0);
      chk("end_busy", busy_o, 0);
`ifdef IMEM_LOADER_CKSUM_EN
      chk("end_we", imem_we_o, 0);
`else
      chk("last_we_with_done", imem_we_o, 32'(nd > 0));
`endif
      @(negedge clk);
      chk("core_rst_after", core_rst_o, 32'(!ok));
      chk("we_after", imem_we_o, 0);
      repeat (2) @(negedge clk);
      chk("write_count", 32'(wa_q.size()), 32'(nd));
      for (int i = 0; i < nd && i < wa_q.size(); i++) begin
         chk($sformatf("waddr[%0d]", i), wa_q[i], 32'(i));
         chk($sformatf("wdata[%0d]", i), wd_q[i], prog[i]);
      end
      if (ck == 32'hdead_beef) $display("note: checksum pattern");
   endtask

   initial begin
      logic [31:0] n;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ready", byte_ready_o, 0);
      chk("rst_we", imem_we_o, 0);
      chk("rst_core_rst", core_rst_o, 1);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_waddr", 32'(imem_waddr_o), 0);
      chk("rst_wdata", imem_wdata_o, 0);
      rst = 1'b0;

      prog[0] = 32'h0000_0013; prog[1] = 32'h0010_0093;
      run_load(32'd2, 0, 1'b0, -1);
      run_load(32'd0, 0, 1'b0, -1);
      run_load(32'd257, 0, 1'b0, -1);
      run_load(32'd2, 50, 1'b0, -1);
      run_load(32'd2, 30, 1'b0, 6);

      wa_q.delete(); wd_q.delete();
      do_start();
      foreach (prog[i]) if (i == 0) begin
         send_byte(8'h02, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
         send_byte(8'h00, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
         send_byte(8'h13, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
      end
      @(negedge clk); bv = 1'b0; rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("midrst_busy", busy_o, 0);
      chk("midrst_ready", byte_ready_o, 0);
      chk("midrst_core_rst", core_rst_o, 1);
      repeat (3) @(negedge clk);
      chk("midrst_no_write", 32'(wa_q.size()), 0);
      run_load(32'd2, 0, 1'b0, -1);
`ifdef IMEM_LOADER_CKSUM_EN
      run_load(32'd2, 0, 1'b1, -1);
      run_load(32'd0, 0, 1'b1, -1);
`endif

      for (int k = 0; k < 6; k++) begin
         n = 32'($urandom_range(1, 12));
         for (int i = 0; i < NREGS; i++) prog[i] = $urandom;
         run_load(n, $urandom_range(0, 40), 1'($urandom_range(0, 1)), -1);
      end
      for (int i = 0; i < NREGS; i++) prog[i] = $urandom;
      run_load(32'(NREGS), 0, 1'b0, -1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
